// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO. Bus writes to TX_ADDR queue whole
// words. The engine sends each word as WORD_W/8 byte frames, least
// significant byte first, with optional parity and 1 or 2 stop bits.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high; pops the head word whenever the FIFO is non-empty
// ST_START  | start bit (low) for BAUD_DIV cycles
// ST_DATA   | 8 data bits of the current byte, LSB first
// ST_PARITY | parity of the current byte (only when PARITY_EN)
// ST_STOP   | STOP_BITS stop bits; next byte starts at once, or back to idle
module uart_tx_fifo #(
   parameter int          WORD_W     = 32,
   parameter int          DEPTH      = 8,
   parameter int          BAUD_DIV   = 868,
   parameter int          PARITY_EN  = 0,
   parameter int          PARITY_ODD = 0,
   parameter int          STOP_BITS  = 1,
   parameter logic [31:0] TX_ADDR    = 32'hFFFF_FFFF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         we,
   input  logic [31:0]                  address,
   input  logic [WORD_W-1:0]            dataIn,
   output logic                         serial,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         busy,
   output logic                         overflow
);

   localparam int LVL_W  = $clog2(DEPTH+1);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(BAUD_DIV);
   localparam int NBYTES = WORD_W / 8;
   localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
   localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic              PAR_ODD   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [WORD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  count_q;
   logic              push_req, push_ok, pop;

   // engine registers and next-state values
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [7:0]        cur_byte_d;
   logic              serial_d;
   logic              baud_wrap;

   assign full     = (count_q == DEPTH_L);
   assign empty    = (count_q == '0);
   assign level    = count_q;
   assign busy     = (state_q != ST_IDLE);

   // A full FIFO still takes a write on the edge where the engine pops.
   assign push_req = we && (address == TX_ADDR);
   assign push_ok  = push_req && (!full || pop);

   // FIFO data array, written only when a push is accepted
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= dataIn;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push_req && full && !pop) overflow <= 1'b1;
      end
   end

   // Engine state register; serial is registered from the next-state value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shreg_q <= '0;
         serial  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shreg_q <= shreg_d;
         serial  <= serial_d;
      end
   end

   // Engine next-state, pop request and line level
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      shreg_d   = shreg_q;
      pop       = 1'b0;
      baud_wrap = (cnt_q == BAUD_LAST);

      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shreg_d = mem[rd_ptr_q];
               byte_d  = '0;
               bit_d   = '0;
               cnt_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_wrap) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_wrap) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PARITY: begin
            if (baud_wrap) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            // bit_q doubles as the stop-bit counter here
            if (baud_wrap) begin
               cnt_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  if (byte_q == LAST_BYTE) begin
                     state_d = ST_IDLE;
                  end else begin
                     byte_d  = byte_q + 1'b1;
                     shreg_d = shreg_q >> 8;
                     state_d = ST_START;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cur_byte_d = shreg_d[7:0];
      case (state_d)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = cur_byte_d[bit_d];
         ST_PARITY: serial_d = (^cur_byte_d) ^ PAR_ODD;
         default:   serial_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances with different framing share one
// bus stimulus; each is compared every cycle with a word-queue model that
// expands each popped word into its expected line waveform.
module tb_uart_tx_fifo;

   localparam int          NI      = 3;
   localparam int          DEPTH   = 4;
   localparam int          BAUD    = 4;
   localparam int          WORD_W  = 32;
   localparam logic [31:0] TX_ADDR = 32'hFFFF_FFFF;
   localparam int          PE_CFG [NI] = '{0, 1, 1};
   localparam int          PO_CFG [NI] = '{0, 0, 1};
   localparam int          SB_CFG [NI] = '{1, 2, 2};

   logic              clk = 1'b0;
   logic              reset;
   logic              we;
   logic [31:0]       address;
   logic [WORD_W-1:0] dataIn;

   logic       serial_w [NI];
   logic       full_w   [NI];
   logic       empty_w  [NI];
   logic [2:0] level_w  [NI];
   logic       busy_w   [NI];
   logic       ovf_w    [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      uart_tx_fifo #(
         .WORD_W    (WORD_W),
         .DEPTH     (DEPTH),
         .BAUD_DIV  (BAUD),
         .PARITY_EN (PE_CFG[g]),
         .PARITY_ODD(PO_CFG[g]),
         .STOP_BITS (SB_CFG[g]),
         .TX_ADDR   (TX_ADDR)
      ) u_dut (
         .clk     (clk),
         .reset   (reset),
         .we      (we),
         .address (address),
         .dataIn  (dataIn),
         .serial  (serial_w[g]),
         .full    (full_w[g]),
         .empty   (empty_w[g]),
         .level   (level_w[g]),
         .busy    (busy_w[g]),
         .overflow(ovf_w[g])
      );
   end

   // reference model: queued words, active word waveform, sticky overflow
   logic [31:0] mq [NI][$];
   bit          wave [NI][256];
   int          wlen [NI];
   int          idx  [NI];
   bit          act  [NI];
   bit          movf [NI];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NI; i++) begin
         mq[i].delete();
         act[i]  = 1'b0;
         idx[i]  = 0;
         movf[i] = 1'b0;
      end
   endfunction

   function automatic void build_wave(input int i, input logic [31:0] w);
      int n;
      logic [7:0] byt;
      n = 0;
      for (int b = 0; b < WORD_W / 8; b++) begin
         byt = w[8*b +: 8];
         for (int k = 0; k < BAUD; k++) wave[i][n++] = 1'b0;
         for (int d = 0; d < 8; d++)
            for (int k = 0; k < BAUD; k++) wave[i][n++] = byt[d];
         if (PE_CFG[i] != 0)
            for (int k = 0; k < BAUD; k++) wave[i][n++] = (^byt) ^ (PO_CFG[i] != 0);
         for (int k = 0; k < SB_CFG[i] * BAUD; k++) wave[i][n++] = 1'b1;
      end
      wlen[i] = n;
   endfunction

   function automatic void model_step();
      bit pop;
      if (!reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NI; i++) begin
         pop = !act[i] && (mq[i].size() > 0);
         if (pop) begin
            build_wave(i, mq[i].pop_front());
            idx[i] = 0;
            act[i] = 1'b1;
         end else if (act[i]) begin
            idx[i]++;
            if (idx[i] == wlen[i]) act[i] = 1'b0;
         end
         if (we && address == TX_ADDR) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(dataIn);
            else movf[i] = 1'b1;
         end
      end
   endfunction

   function automatic bit model_idle();
      bit r;
      r = 1'b1;
      for (int i = 0; i < NI; i++)
         if (act[i] || mq[i].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic cyc();
      logic [7:0] got, exp;
      int sz;
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         sz  = mq[i].size();
         got = {serial_w[i], busy_w[i], full_w[i], empty_w[i], ovf_w[i], level_w[i]};
         exp = {(act[i] ? wave[i][idx[i]] : 1'b1), act[i], (sz == DEPTH), (sz == 0),
                movf[i], 3'(sz)};
         check_val($sformatf("status%0d", i), {24'd0, got}, {24'd0, exp});
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      we      = 1'b1;
      address = addr;
      dataIn  = data;
      cyc();
      we      = 1'b0;
   endtask

   task automatic idle(input int n);
      we = 1'b0;
      for (int k = 0; k < n; k++) cyc();
   endtask

   int blen [NI];

   task automatic drain(input int budget);
      int c;
      c = 0;
      for (int i = 0; i < NI; i++) blen[i] = 0;
      we = 1'b0;
      while (!model_idle() && c < budget) begin
         cyc();
         for (int i = 0; i < NI; i++) if (busy_w[i]) blen[i]++;
         c++;
      end
      check_val("drain_done", {31'd0, model_idle()}, 32'd1);
      for (int i = 0; i < NI; i++)
         check_val($sformatf("drain_busy%0d", i), {31'd0, busy_w[i]}, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      int r;
      reset   = 1'b0;
      we      = 1'b0;
      address = '0;
      dataIn  = '0;
      model_reset();
      repeat (3) cyc();
      reset = 1'b1;
      cyc();
      check_val("rst_serial", {31'd0, serial_w[0]}, 32'd1);
      check_val("rst_empty",  {31'd0, empty_w[0]},  32'd1);
      check_val("rst_level",  {29'd0, level_w[0]}, 32'd0);
      check_val("rst_busy",   {31'd0, busy_w[0]},   32'd0);
      check_val("rst_ovf",    {31'd0, ovf_w[0]},    32'd0);

      // single word, then frame length per configuration
      wr(TX_ADDR, 32'hAAAA_AAAA);
      check_val("lat_level", {29'd0, level_w[0]}, 32'd1);
      drain(1000);
      check_val("busy_len0", blen[0], 32'd160);
      check_val("busy_len1", blen[1], 32'd192);
      check_val("busy_len2", blen[2], 32'd192);

      wr(TX_ADDR, 32'h8765_4321);
      drain(1000);

      // address filter
      wr(32'h0000_0000, 32'h1E2D_3C4B);
      idle(3);
      check_val("filt_level",  {29'd0, level_w[0]}, 32'd0);
      check_val("filt_serial", {31'd0, serial_w[0]}, 32'd1);

      // parity / stop-bit word
      wr(TX_ADDR, 32'h0000_0021);
      drain(1000);

      // overflow: six back-to-back writes
      for (int k = 0; k < 6; k++) wr(TX_ADDR, 32'h1111_1111 * (k + 1));
      check_val("ovf_full",  {31'd0, full_w[0]},   32'd1);
      check_val("ovf_level", {29'd0, level_w[0]},  32'd4);
      check_val("ovf_flag",  {31'd0, ovf_w[0]},    32'd1);
      // keep writing while full so a write lands on the pop edge
      for (int k = 0; k < 200; k++) wr(TX_ADDR, $urandom);
      drain(5000);
      check_val("ovf_sticky", {31'd0, ovf_w[0]}, 32'd1);
      check_val("ovf_empty",  {31'd0, empty_w[0]}, 32'd1);

      // reset in the middle of a data bit
      wr(TX_ADDR, 32'hF0F0_F0F0);
      wr(TX_ADDR, 32'h1234_5678);
      wr(TX_ADDR, 32'h9ABC_DEF0);
      idle(20);
      reset = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check_val($sformatf("mid_serial%0d", i), {31'd0, serial_w[i]}, 32'd1);
         check_val($sformatf("mid_level%0d", i),  {29'd0, level_w[i]},  32'd0);
         check_val($sformatf("mid_busy%0d", i),   {31'd0, busy_w[i]},   32'd0);
      end
      idle(2);
      reset = 1'b1;
      idle(2);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            wr(TX_ADDR, $urandom);
         end else if (r < 4) begin
            a = $urandom;
            if (a == TX_ADDR) a = 32'h0;
            wr(a, $urandom);
         end else if (r < 5) begin
            for (int j = 0; j < 6; j++) wr(TX_ADDR, $urandom);
         end else begin
            address = TX_ADDR;
            dataIn  = $urandom;
            idle(1);
         end
      end
      drain(5000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
